signed_divide: RTL and testbench

- Sequential signed two's-complement divider; the inverse operation of the team's signed multiply/shift blocks.
- Computes quotient and remainder of dividend / divisor using restoring division on magnitudes, then applies sign correction.
- Result rounds toward zero.
- Used wherever a scaled value must be brought back down. Start/done handshake; one division in flight at a time.

---
 rtl/signed_divide.sv | 186 ++++++++++++++++++
 tb/tb_signed_divide.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divide.sv
// signed_divide: sequential signed two's-complement divider.
// Restoring division on operand magnitudes, one quotient bit per cycle (MSB
// first), followed by a sign-correction step. The result rounds toward zero.
// Divide-by-zero and most-negative / -1 bypass the iteration and finish early.
// Optional build macro: SIGNED_DIVIDE_REMAINDER_EN. When it is defined, the
// signed remainder is produced. When it is undefined, the remainder port is
// tied to 0.
module signed_divide #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // The dividend shift register shifts left. It releases dividend bits at
    // the MSB and collects quotient bits at the LSB. When the iteration ends,
    // it holds the quotient magnitude.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic             q_sign_q, q_sign_d;
    logic             dz_pend_q, dz_pend_d;
    logic             ov_pend_q, ov_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             done_q, done_d;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
    logic             r_sign_q, r_sign_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
`endif

    // Magnitudes are unsigned, so |most-negative| = 2^(WIDTH-1) fits in WIDTH bits.
    logic [WIDTH-1:0] dvd_abs, dsr_abs;
    assign dvd_abs = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign dsr_abs = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    // Restoring step. Shift in the next dividend bit, then trial-subtract.
    // The partial remainder always stays below |divisor| <= 2^(WIDTH-1).
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH-1:0] prem_step;
    logic             unused_trial_bit;
    assign shifted          = {prem_q, dvd_q[WIDTH-1]};
    assign trial            = {1'b0, shifted} - {1'b0, dsr_q};
    assign q_bit            = ~trial[WIDTH+1];
    assign prem_step        = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign unused_trial_bit = trial[WIDTH];

    // Next-state and datapath decode for the IDLE / CALC / FIN sequence
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        prem_d     = prem_q;
        q_sign_d   = q_sign_q;
        dz_pend_d  = dz_pend_q;
        ov_pend_d  = ov_pend_q;
        quotient_d = quotient_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        done_d     = 1'b0;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
        r_sign_d    = r_sign_q;
        remainder_d = remainder_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = dvd_abs;
                    dsr_d     = {1'b0, dsr_abs};
                    q_sign_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
`ifdef SIGNED_DIVIDE_REMAINDER_EN
                    r_sign_d  = dividend[WIDTH-1];
`endif
                    count_d   = '0;
                    dz_d      = 1'b0;
                    ov_d      = 1'b0;
                    dz_pend_d = (divisor == '0);
                    ov_pend_d = (dividend == MOST_NEG) && (divisor == '1);
                    // Divide-by-zero returns the dividend as the remainder. Preloading
                    // its magnitude lets the normal sign correction restore it.
                    // Overflow needs no preload. The captured magnitude 2^(WIDTH-1)
                    // with a positive sign already encodes the most-negative quotient.
                    prem_d    = (divisor == '0) ? dvd_abs : '0;
                    state_d   = ((divisor == '0) ||
                                 ((dividend == MOST_NEG) && (divisor == '1))) ? FIN : CALC;
                end
            end
            CALC: begin
                prem_d = prem_step;
                dvd_d  = {dvd_q[WIDTH-2:0], q_bit};
                if (count_q == LAST_STEP) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            FIN: begin
                if (dz_pend_q) begin
                    quotient_d = '1;
                end else begin
                    quotient_d = q_sign_q ? ({WIDTH{1'b0}} - dvd_q) : dvd_q;
                end
`ifdef SIGNED_DIVIDE_REMAINDER_EN
                remainder_d = r_sign_q ? ({WIDTH{1'b0}} - prem_q) : prem_q;
`endif
                dz_d    = dz_pend_q;
                ov_d    = ov_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            prem_q     <= '0;
            q_sign_q   <= 1'b0;
            dz_pend_q  <= 1'b0;
            ov_pend_q  <= 1'b0;
            quotient_q <= '0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
            r_sign_q    <= 1'b0;
            remainder_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            prem_q     <= prem_d;
            q_sign_q   <= q_sign_d;
            dz_pend_q  <= dz_pend_d;
            ov_pend_q  <= ov_pend_d;
            quotient_q <= quotient_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
            done_q     <= done_d;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
            r_sign_q    <= r_sign_d;
            remainder_q <= remainder_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
    assign remainder   = remainder_q;
`else
    assign remainder   = '0;
`endif

endmodule

// File: tb/tb_signed_divide.sv
// tb_signed_divide: table-driven vectors checked through a scoreboard queue,
// plus hand-written sequences for back-to-back, ignored start and mid-run reset.
module tb_signed_divide;

    localparam int W = 4;
`ifdef SIGNED_DIVIDE_REMAINDER_EN
    localparam bit REM_ON = 1'b1;
`else
    localparam bit REM_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    signed_divide #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           due;
    } exp_t;

    vec_t vecs [16];
    int   nv = 0;
    exp_t sbq [$];
    exp_t mon_e;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   last_done = -100;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic add_vec(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic dz, input logic ov);
        vecs[nv] = '{name: n, a: a, b: b, q: q, r: r, dz: dz, ov: ov};
        nv++;
    endtask

    // Expected result queued at the accept edge; due = cycle count when done shows
    task automatic push(input vec_t v);
        exp_t e;
        e.name = v.name;
        e.q    = v.q;
        e.r    = REM_ON ? v.r : '0;
        e.dz   = v.dz;
        e.ov   = v.ov;
        e.due  = cyc + ((v.dz || v.ov) ? 1 : W + 1);
        sbq.push_back(e);
        $display("issue %-6s dividend=%b divisor=%b at cycle %0d", v.name, v.a, v.b, cyc);
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        push(v);
        check({v.name, "/busy_after_accept"}, 32'(busy), 32'd1);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge clk);
        #2;
        check("drain_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    // Output monitor: pops one expectation per done pulse and compares
    always @(posedge clk) begin
        #1;
        if (done) begin
            check("done_one_cycle", 32'(prev_done), 32'd0);
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1, required 0 (nothing pending) at cycle %0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                $display("done  %-6s q=%b r=%b dz=%b ov=%b at cycle %0d",
                         mon_e.name, quotient, remainder, div_by_zero, overflow, cyc);
                check({mon_e.name, "/quotient"},  32'(quotient),    32'(mon_e.q));
                check({mon_e.name, "/remainder"}, 32'(remainder),   32'(mon_e.r));
                check({mon_e.name, "/div_by_0"},  32'(div_by_zero), 32'(mon_e.dz));
                check({mon_e.name, "/overflow"},  32'(overflow),    32'(mon_e.ov));
                check({mon_e.name, "/latency"},   cyc,              mon_e.due);
                check({mon_e.name, "/busy_low"},  32'(busy),        32'd0);
            end
            last_done = cyc;
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1;
        vec_t v;

        //      name     a        b        q        r        dz    ov
        add_vec("7/2",   4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0);
        add_vec("-7/2",  4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);
        add_vec("-8/3",  4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0, 1'b0);
        add_vec("6/-4",  4'b0110, 4'b1100, 4'b1111, 4'b0010, 1'b0, 1'b0);
        add_vec("5/0",   4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0);
        add_vec("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1);
        add_vec("-8/1",  4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0);
        add_vec("7/-1",  4'b0111, 4'b1111, 4'b1001, 4'b0000, 1'b0, 1'b0);
        add_vec("-1/4",  4'b1111, 4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b0);
        add_vec("-8/0",  4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0);
        add_vec("3/7",   4'b0011, 4'b0111, 4'b0000, 4'b0011, 1'b0, 1'b0);
        add_vec("-7/-3", 4'b1001, 4'b1101, 4'b0010, 4'b1111, 1'b0, 1'b0);
        add_vec("0/5",   4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add_vec("7/7",   4'b0111, 4'b0111, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add_vec("-8/-8", 4'b1000, 4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0);
        add_vec("-8/2",  4'b1000, 4'b0010, 4'b1100, 4'b0000, 1'b0, 1'b0);

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy",      32'(busy),        32'd0);
        check("reset/done",      32'(done),        32'd0);
        check("reset/quotient",  32'(quotient),    32'd0);
        check("reset/remainder", 32'(remainder),   32'd0);
        check("reset/div_by_0",  32'(div_by_zero), 32'd0);
        check("reset/overflow",  32'(overflow),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            run_op(vecs[i]);
            wait_drain();
        end

        // Back-to-back: start held high; the second operation is taken in the done cycle
        @(negedge clk);
        dividend = 4'b0011;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(posedge clk);
        #1;
        v = '{name: "b2b-1", a: 4'b0011, b: 4'b0001, q: 4'b0011, r: 4'b0000, dz: 1'b0, ov: 1'b0};
        push(v);
        dividend = 4'b0110;
        divisor  = 4'b0011;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b/first_done_seen", 32'(done), 32'd1);
        d1 = cyc;
        @(posedge clk);
        #1;
        v = '{name: "b2b-2", a: 4'b0110, b: 4'b0011, q: 4'b0010, r: 4'b0000, dz: 1'b0, ov: 1'b0};
        push(v);
        start = 1'b0;
        wait_drain();
        check("b2b/done_spacing", last_done - d1, 6);

        // A start pulse while busy must be ignored
        v = '{name: "busy", a: 4'b0111, b: 4'b0010, q: 4'b0011, r: 4'b0001, dz: 1'b0, ov: 1'b0};
        run_op(v);
        @(negedge clk);
        dividend = 4'b0001;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_drain();
        repeat (8) @(posedge clk);
        #1;
        check("busy/ignored_start_idle", 32'(busy), 32'd0);

        // Reset at edge 3 of a 7 / 2 run: no done pulse and all outputs cleared
        @(negedge clk);
        dividend = 4'b0111;
        divisor  = 4'b0010;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort/busy_running", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort/busy",      32'(busy),        32'd0);
        check("abort/done",      32'(done),        32'd0);
        check("abort/quotient",  32'(quotient),    32'd0);
        check("abort/remainder", 32'(remainder),   32'd0);
        check("abort/div_by_0",  32'(div_by_zero), 32'd0);
        check("abort/overflow",  32'(overflow),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("abort/still_idle", 32'(busy), 32'd0);
        v = '{name: "post", a: 4'b0111, b: 4'b0010, q: 4'b0011, r: 4'b0001, dz: 1'b0, ov: 1'b0};
        run_op(v);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
